// File: rtl/switch_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : switch_clock_scheduler
// Purpose  : Programmable period/high-time sequencer for the PMOD switching
//            clock enable. It has start/stop control and a double-buffered
//            valid/ready configuration port that takes effect only on period
//            boundaries. It also drives a complementary enable output.
//            Optional macro SW_DEAD_TIME_EN adds DEAD_CYC dead-band cycles
//            around the complementary output and extends config validation.
// Revision : 1.0 - initial release
// ============================================================================
module switch_clock_scheduler #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 48000,
    parameter int DEF_HIGH   = 24000,
    parameter int DEAD_CYC   = 4
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    output logic             cfg_err_o,
    output logic             sw_out_o,
    output logic             sw_out_n_o,
    output logic             running_o,
    output logic             period_tick_o
);

    localparam int               c_EW         = CNT_W + 1;
    localparam logic [CNT_W-1:0] c_DEF_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] c_DEF_HIGH   = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] c_ZERO       = '0;
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TWO        = CNT_W'(2);
`ifdef SW_DEAD_TIME_EN
    localparam logic [c_EW-1:0]  c_DEAD       = c_EW'(DEAD_CYC);
    localparam logic [c_EW-1:0]  c_MIN_GAP    = c_EW'(2 * DEAD_CYC + 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Architectural state
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] per_q,       per_d;
    logic [CNT_W-1:0] high_q,      high_d;
    logic             pend_q,      pend_d;
    logic [CNT_W-1:0] pend_per_q,  pend_per_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             stop_pend_q, stop_pend_d;

    // Registered outputs
    logic sw_q,    sw_d;
    logic swn_q,   swn_d;
    logic run_q,   run_d;
    logic tick_q,  tick_d;
    logic err_q,   err_d;
    logic ready_q, ready_d;

    logic w_xfer;
    logic w_cfg_ok;
    logic w_gap_ok;
    logic w_last;

    assign w_xfer = cfg_valid_i && ready_q;
    assign w_last = (cnt_q == (per_q - c_ONE));

`ifdef SW_DEAD_TIME_EN
    // The low phase must fit both dead bands plus at least one complementary cycle
    assign w_gap_ok = (({1'b0, cfg_period_i} - {1'b0, cfg_high_i}) >= c_MIN_GAP);
`else
    assign w_gap_ok = 1'b1;
`endif

    assign w_cfg_ok = (cfg_period_i >= c_TWO) && (cfg_high_i != c_ZERO) &&
                      (cfg_high_i < cfg_period_i) && w_gap_ok;

    // Next-state: sequencing, boundary-aligned config apply, config capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        high_d      = high_q;
        pend_d      = pend_q;
        pend_per_d  = pend_per_q;
        pend_high_d = pend_high_q;
        stop_pend_d = stop_pend_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending slot is drained immediately while idle
                if (pend_q) begin
                    per_d  = pend_per_q;
                    high_d = pend_high_q;
                    pend_d = 1'b0;
                end
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                    cnt_d   = c_ZERO;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    cnt_d = c_ZERO;
                    if (pend_q) begin
                        per_d  = pend_per_q;
                        high_d = pend_high_q;
                        pend_d = 1'b0;
                    end
                    // A stop arriving on the last cycle still ends this period
                    if (stop_pend_q || stop_i) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + c_ONE;
                    if (stop_i) begin
                        stop_pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = c_ZERO;
            end
        endcase

        // Transfer only when the slot was free, so it never collides with an apply
        if (w_xfer) begin
            if (w_cfg_ok) begin
                pend_d      = 1'b1;
                pend_per_d  = cfg_period_i;
                pend_high_d = cfg_high_i;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Output decode from next-state so registered outputs align with the count
    always_comb begin
        run_d   = (state_d == ST_RUN);
        sw_d    = run_d && (cnt_d < high_d);
        tick_d  = run_d && (cnt_d == (per_d - c_ONE));
        ready_d = !pend_d;
`ifdef SW_DEAD_TIME_EN
        swn_d   = run_d &&
                  ({1'b0, cnt_d} >= ({1'b0, high_d} + c_DEAD)) &&
                  (({1'b0, cnt_d} + c_DEAD) < {1'b0, per_d});
`else
        swn_d   = run_d && !(cnt_d < high_d);
`endif
    end

    // State and output registers; reset aborts any period in progress
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= c_ZERO;
            per_q       <= c_DEF_PERIOD;
            high_q      <= c_DEF_HIGH;
            pend_q      <= 1'b0;
            pend_per_q  <= c_ZERO;
            pend_high_q <= c_ZERO;
            stop_pend_q <= 1'b0;
            sw_q        <= 1'b0;
            swn_q       <= 1'b0;
            run_q       <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            high_q      <= high_d;
            pend_q      <= pend_d;
            pend_per_q  <= pend_per_d;
            pend_high_q <= pend_high_d;
            stop_pend_q <= stop_pend_d;
            sw_q        <= sw_d;
            swn_q       <= swn_d;
            run_q       <= run_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign cfg_ready_o   = ready_q;
    assign cfg_err_o     = err_q;
    assign sw_out_o      = sw_q;
    assign sw_out_n_o    = swn_q;
    assign running_o     = run_q;
    assign period_tick_o = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_clock_scheduler
// Purpose  : Self-checking bench for switch_clock_scheduler: a table of config
//            offers, hand-written multi-cycle sequences and a randomized phase,
//            all cross-checked every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_clock_scheduler;

    localparam int CNT_W = 16;
    localparam int DEF_P = 48000;
    localparam int DEF_H = 24000;
    localparam int DEAD  = 1;
`ifdef SW_DEAD_TIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             cfg_ready, cfg_err, sw_out, sw_out_n, running, period_tick;

    switch_clock_scheduler #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_P),
        .DEF_HIGH   (DEF_H),
        .DEAD_CYC   (DEAD)
    ) dut (
        .clk_i         (clk),
        .clr_n_i       (clr_n),
        .start_i       (start),
        .stop_i        (stop),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_period_i  (cfg_period),
        .cfg_high_i    (cfg_high),
        .cfg_err_o     (cfg_err),
        .sw_out_o      (sw_out),
        .sw_out_n_o    (sw_out_n),
        .running_o     (running),
        .period_tick_o (period_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_run, m_stop_pend, m_err;
    int m_cnt, m_P, m_H;
    int q_p[$];
    int q_h[$];

    function automatic bit cfg_legal(input int p, input int h);
        bit ok;
        ok = (p >= 2) && (h >= 1) && (h < p);
        if (DEAD_EN) ok = ok && ((p - h) >= 2 * DEAD + 1);
        return ok;
    endfunction

    task automatic model_reset();
        m_run = 0; m_stop_pend = 0; m_err = 0;
        m_cnt = 0; m_P = DEF_P; m_H = DEF_H;
        q_p.delete(); q_h.delete();
    endtask

    task automatic model_step(input bit st, input bit sp, input bit v, input int p, input int h);
        bit slot_free, at_end, have_cfg;
        slot_free = (q_p.size() == 0);
        at_end    = m_run && (m_cnt == m_P - 1);
        have_cfg  = !slot_free;
        m_err     = 0;
        if (!m_run) begin
            if (have_cfg) begin m_P = q_p.pop_front(); m_H = q_h.pop_front(); end
            if (st && !sp) begin m_run = 1; m_cnt = 0; end
        end else begin
            if (sp) m_stop_pend = 1;
            if (at_end) begin
                if (have_cfg) begin m_P = q_p.pop_front(); m_H = q_h.pop_front(); end
                m_cnt = 0;
                if (m_stop_pend) begin m_run = 0; m_stop_pend = 0; end
            end else begin
                m_cnt++;
            end
        end
        if (v && slot_free) begin
            if (cfg_legal(p, h)) begin q_p.push_back(p); q_h.push_back(h); end
            else m_err = 1;
        end
    endtask

    function automatic logic [5:0] model_outputs();
        bit sw, swn;
        sw = m_run && (m_cnt < m_H);
        if (DEAD_EN) swn = m_run && (m_cnt >= m_H + DEAD) && (m_cnt < m_P - DEAD);
        else         swn = m_run && !(m_cnt < m_H);
        return {sw, swn, m_run, (m_run && m_cnt == m_P - 1), m_err, (q_p.size() == 0)};
    endfunction

    // Model tracks the DUT clock and the asynchronous clear
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) model_reset();
        else        model_step(start, stop, cfg_valid, int'(cfg_period), int'(cfg_high));
    end

    // Whole-output cross-check every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en)
            check("model_outputs",
                  {26'd0, sw_out, sw_out_n, running, period_tick, cfg_err, cfg_ready},
                  {26'd0, model_outputs()});
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_cnt(input int k, input string name);
        int n;
        n = 0;
        while ((!m_run || m_cnt != k) && n < 200) begin @(negedge clk); n++; end
        check({name, "_reached"}, 32'(n < 200), 32'd1);
    endtask

    typedef struct {
        int p;
        int h;
        bit err;
    } cfg_vec_t;

    cfg_vec_t vec[10];

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [9:0] pat_sw, pat_swn, pat_tick;
        logic [5:0] pat6;
        int hi, ticks, tick_at, n;

        vec[0] = '{10, 10, 1'b1};
        vec[1] = '{1,  0,  1'b1};
        vec[2] = '{0,  0,  1'b1};
        vec[3] = '{5,  0,  1'b1};
        vec[4] = '{9,  12, 1'b1};
        vec[5] = '{2,  1,  DEAD_EN};
        vec[6] = '{65535, 1, 1'b0};
        vec[7] = '{6,  3,  1'b0};
        vec[8] = '{6,  4,  DEAD_EN};
        vec[9] = '{10, 4,  1'b0};

        // Reset values while clear is held
        repeat (3) @(negedge clk);
        check("rst_sw_out", 32'(sw_out), 0);
        check("rst_sw_out_n", 32'(sw_out_n), 0);
        check("rst_running", 32'(running), 0);
        check("rst_period_tick", 32'(period_tick), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        chk_en = 1'b1;
        clr_n  = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_sw_out_n", 32'(sw_out_n), 0);

        // Default 48000/24000 period after reset
        pulse_start();
        hi = 0; ticks = 0; tick_at = -1;
        for (int i = 0; i < DEF_P; i++) begin
            if (sw_out) hi++;
            if (period_tick) begin ticks++; tick_at = i; end
            @(negedge clk);
        end
        check("def_high_cycles", 32'(hi), 32'(DEF_H));
        check("def_tick_count", 32'(ticks), 1);
        check("def_tick_pos", 32'(tick_at), 32'(DEF_P - 1));
        check("def_wrap_sw", 32'(sw_out), 1);

        // Asynchronous clear mid-period aborts immediately
        repeat (100) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("async_clr_outs", {28'd0, sw_out, sw_out_n, running, period_tick}, 0);
        check("async_clr_ready", 32'(cfg_ready), 1);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // Config offers in IDLE: table of accept/reject outcomes
        foreach (vec[i]) begin
            cfg_valid = 1'b1; cfg_period = CNT_W'(vec[i].p); cfg_high = CNT_W'(vec[i].h);
            @(negedge clk);
            cfg_valid = 1'b0;
            check($sformatf("cfg_err_%0d", i), 32'(cfg_err), 32'(vec[i].err));
            check($sformatf("cfg_ready_%0d", i), 32'(cfg_ready), 32'(vec[i].err));
            @(negedge clk);
            check($sformatf("cfg_ready_free_%0d", i), 32'(cfg_ready), 1);
        end

        // 10/4 pattern from start
        pat_sw   = 10'b1111000000;
        pat_swn  = DEAD_EN ? 10'b0000011110 : 10'b0000111111;
        pat_tick = 10'b0000000001;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("p10_sw_%0d", i), 32'(sw_out), 32'(pat_sw[9 - i]));
            check($sformatf("p10_swn_%0d", i), 32'(sw_out_n), 32'(pat_swn[9 - i]));
            check($sformatf("p10_tick_%0d", i), 32'(period_tick), 32'(pat_tick[9 - i]));
            @(negedge clk);
        end

        // Graceful stop at cnt 3 drains cnt 4..9
        wait_cnt(3, "stop_wait");
        pulse_stop();
        n = 0;
        while (running && n < 50) begin @(negedge clk); n++; end
        check("stop_drain_cycles", 32'(n), 6);
        check("stop_outs_zero", {29'd0, sw_out, sw_out_n, period_tick}, 0);

        // Start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'(running), 0);
        repeat (3) @(negedge clk);
        check("start_stop_idle_later", 32'(running), 0);

        // Config 6/3 offered at cnt 2 applies at the next boundary
        pulse_start();
        wait_cnt(2, "cfg_run_wait");
        cfg_valid = 1'b1; cfg_period = 16'd6; cfg_high = 16'd3;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("run_cfg_ready_held", 32'(cfg_ready), 0);
        wait_cnt(9, "cfg_run_end");
        check("run_cfg_ready_end", 32'(cfg_ready), 0);
        check("run_old_tick", 32'(period_tick), 1);
        @(negedge clk);
        check("run_cfg_ready_free", 32'(cfg_ready), 1);
        pat6 = '0; tick_at = -1;
        for (int i = 0; i < 6; i++) begin
            pat6 = {pat6[4:0], sw_out};
            if (period_tick && tick_at < 0) tick_at = i;
            @(negedge clk);
        end
        check("new_6_3_sw", 32'(pat6), 32'(6'b111000));
        check("new_6_3_tick", 32'(tick_at), 5);
        pulse_stop();
        n = 0;
        while (running && n < 50) begin @(negedge clk); n++; end
        check("stop2_reached", 32'(n < 50), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_period = CNT_W'($urandom_range(0, 20));
            cfg_high   = CNT_W'($urandom_range(0, int'(cfg_period) + 1));
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_clock_scheduler.md
Name: switch_clock_scheduler

Overview:
Run-time controller for the switching-clock enable that drives the high-speed PMOD switch outputs. It replaces a fixed divide-by-48000, 50% generator with a programmable period/high-time sequencer. It provides a start/stop control and a valid/ready configuration port whose updates are double-buffered and applied only on period boundaries. It also drives a complementary output, so downstream switch drivers never see a torn or overlapping cycle.

Parameters:
CNT_W, 16, width of period/high-time counters and config fields
DEF_PERIOD, 48000, active period in clk cycles after reset (100 MHz -> 2.083 kHz)
DEF_HIGH, 24000, active high-time in clk cycles after reset
DEAD_CYC, 4, dead-band cycles on each side of sw_out_n (used only with SW_DEAD_TIME_EN)

Ports:
clk  in  1  system clock, 100 MHz
clr_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins switching from IDLE
stop  in  1  single-cycle pulse; graceful stop at end of current period
cfg_valid  in  1  config offer
cfg_ready  out  1  config slot free
cfg_period  in  CNT_W  requested period in cycles
cfg_high  in  CNT_W  requested high-time in cycles
cfg_err  out  1  one-cycle pulse: offered config rejected
sw_out  out  1  switch enable (high phase)
sw_out_n  out  1  complementary switch enable
running  out  1  high while in RUN
period_tick  out  1  one-cycle pulse on last cycle of each period

Behaviour:
- Reset (clr_n low, async): state=IDLE, cnt=0, active period/high = DEF_PERIOD/DEF_HIGH, no config pending, stop_pending=0.
- Reset output values: sw_out=0, sw_out_n=0, running=0, period_tick=0, cfg_err=0, cfg_ready=1.
- Reset mid-period aborts immediately. No completion of the current period.
- All outputs are registered.
- States are IDLE and RUN.
- IDLE -> RUN: on start=1 and stop=0. Next cycle: running=1, cnt=0, sw_out=1.
- Start and stop in the same cycle in IDLE: stop wins; block stays in IDLE.
- Stop in IDLE: ignored. Start in RUN: ignored.
- RUN counting: cnt counts 0..P-1 and wraps to 0, where P is the active period and H is the active high-time.
- sw_out=1 for cnt in [0,H), else 0.
- sw_out_n = ~sw_out while in RUN; 0 in IDLE.
- period_tick=1 on the cycle where cnt==P-1.
- Stop in RUN sets stop_pending. At cnt==P-1 the block goes to IDLE. The next cycle has all switch outputs 0 and running=0.
- A repeated stop while stop_pending=1 has no further effect. stop_pending clears on entering IDLE.
- Config handshake: transfer occurs when cfg_valid && cfg_ready. There is one pending slot; cfg_ready=0 while the slot is full.
- Config validation at transfer: accept only if cfg_period>=2, 1<=cfg_high<cfg_period, and (with SW_DEAD_TIME_EN) cfg_period-cfg_high>=2*DEAD_CYC+1.
- A rejected config causes a cfg_err pulse on the next cycle. The slot stays empty and active values are unchanged.
- Applying a pending config in IDLE: copied to active on the next cycle.
- Applying a pending config in RUN: copied at the wrap edge (cnt P-1 -> 0). The new P/H govern from cnt=0 of the next period.
- A config transferred in the same cycle as cnt==P-1 waits for the following boundary.
- When a pending config is applied, the slot is freed and cfg_ready=1 on the next cycle.
- A config pending at graceful stop is applied on entering IDLE.

Optional Feature:
Macro SW_DEAD_TIME_EN.
- Defined: sw_out_n=1 only for cnt in [H+DEAD_CYC, P-DEAD_CYC). sw_out and sw_out_n are never both 1, and there are at least DEAD_CYC cycles with both 0 at each transition. Config validation includes the dead-band rule.
- Undefined: sw_out_n = ~sw_out in RUN, DEAD_CYC is ignored, and the dead-band validation rule is omitted.

Test Plan:
- Reset release, pulse start -> sw_out high for 24000 cycles, low for 24000; period_tick every 48000 cycles; sw_out_n=0 before start.
- Config 10/4 in IDLE, then start -> sw_out pattern 1111000000 repeating; period_tick on cnt==9.
- In RUN with 10/4, offer 6/3 at cnt=2 -> remainder of the current period keeps 10/4; 6/3 takes effect from the next cnt=0; cfg_ready low until then.
- Offer cfg_high=10, cfg_period=10 -> cfg_err pulse one cycle; active config unchanged; cfg_ready stays 1.
- Stop at cnt=3 of a 10-cycle period -> period completes to cnt=9; running=0 and all outputs 0 on the next cycle; start+stop together in IDLE -> no start.
- With SW_DEAD_TIME_EN, DEAD_CYC=1, config 10/4 -> sw_out_n high only for cnt 5..8. Config 6/4 -> cfg_err. Assert clr_n low mid-period -> all outputs 0 immediately.
